// File: rtl/serial2parallel_pkg.sv
// Shared definitions for the serial2parallel receiver: FSM state encoding and
// counter width helper.
package serial2parallel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Bits needed to hold any value from 0 to max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/serial2parallel_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a delay flop that
// turns the synchronized level into a single-cycle rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/serial2parallel.sv
// Oversampling receiver for a framed serial stream (s_clr, s_clk, s_dat):
// reassembles DATA_BITS bits into a word, with abort on re-clear or timeout.
module serial2parallel
  import serial2parallel_pkg::*;
#(
  parameter int DATA_BITS      = 32,
  parameter int READ_DIRECTION = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_clr,
  input  logic                 s_dat,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           state
);

  localparam int CNT_W  = cnt_width(DATA_BITS);
  localparam int TCNT_W = cnt_width(TIMEOUT_CYCLES);

  logic clk_lvl, clk_rise, clr_lvl, dat_lvl;
  logic unused_clk_lvl, unused_clr_rise, unused_dat_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .din(s_clk), .level(clk_lvl), .rise(clk_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst(rst), .din(s_clr), .level(clr_lvl), .rise(unused_clr_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst(rst), .din(s_dat), .level(dat_lvl), .rise(unused_dat_rise)
  );
  assign unused_clk_lvl = clk_lvl;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, shifted;
  logic [DATA_BITS:0]   cat;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, err_q, err_d;

  // The extra bit in cat keeps both shift directions legal for DATA_BITS = 1.
  always_comb begin
    if (READ_DIRECTION != 0) begin
      cat     = {shreg_q, dat_lvl};
      shifted = cat[DATA_BITS-1:0];
    end else begin
      cat     = {dat_lvl, shreg_q};
      shifted = cat[DATA_BITS:1];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tcnt_d  = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_lvl) state_d = CLEAR;
      end
      CLEAR: begin
        shreg_d = '0;
        cnt_d   = '0;
        if (!clr_lvl) state_d = SHIFT;
      end
      SHIFT: begin
        // Priority: re-clear, then serial clock edge, then timeout.
        if (clr_lvl) begin
          err_d   = (cnt_q != '0);
          state_d = CLEAR;
        end else if (clk_rise) begin
          shreg_d = shifted;
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            data_d  = shifted;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q == CLEAR) || (state_q == SHIFT);
  assign state = state_q;

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Receiver counterpart to the parallel2serial transmitter. Captures a framed serial stream (s_clr, s_clk, s_dat) and reassembles it into a DATA_BITS-wide word.
- Runs on the main clock and oversamples the serial lines, so no second clock domain exists.
- Uses: on-board loopback checking of the display/shift-register link, and as the input stage for boards that receive serial data.

Parameters:
- DATA_BITS, 32: frame length in bits.
- READ_DIRECTION, 1: 1 = first received bit is the MSB; 0 = first received bit is the LSB. Must match the transmitter.
- SYNC_STAGES, 2: synchronizer depth on each serial input; minimum 2.
- TIMEOUT_CYCLES, 64: number of main-clock cycles without an s_clk rising edge, mid-frame, before the frame is aborted.

Ports:
- clk  input  1  main clock.
- rst  input  1  asynchronous reset, active-low.
- s_clk  input  1  serial clock; data is valid at its rising edge.
- s_clr  input  1  serial clear, active-high; marks the start of a frame.
- s_dat  input  1  serial data.
- data  output  DATA_BITS  last complete frame; held until the next complete frame.
- valid  output  1  one-cycle pulse when data updates.
- busy  output  1  high in the CLEAR and SHIFT states.
- err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (rst low, asynchronous): all synchronizer flops, the shift register, the bit counter, the timeout counter and data are 0. valid, busy and err are 0. State is IDLE.
- Input conditioning:
  - s_clk, s_clr and s_dat each pass through SYNC_STAGES flops, so all three have identical delay.
  - Rising edge (rise) = synchronized s_clk high AND its one-cycle-delayed copy low.
  - The main clock must run at least 4x s_clk, so each s_clk phase lasts at least 2 clk cycles.
- IDLE:
  - busy = 0; s_clk edges are ignored.
  - Synchronized s_clr high -> CLEAR.
- CLEAR:
  - Shift register and counter are cleared every cycle.
  - Stays in CLEAR while s_clr is high; s_clr low -> SHIFT.
- SHIFT, on each rise:
  - Sample synchronized s_dat in the same cycle as rise.
  - READ_DIRECTION=1: shreg <= {shreg[DATA_BITS-2:0], bit}.
  - READ_DIRECTION=0: shreg <= {bit, shreg[DATA_BITS-1:1]}.
  - The counter increments and the timeout counter is cleared.
- Frame completion:
  - A rise with counter == DATA_BITS-1 completes the frame.
  - On that same clk edge, data is loaded with the final shifted value and valid pulses for 1 cycle; the counter clears and the state returns to IDLE.
  - Latency: valid goes high SYNC_STAGES+1 clk edges after the first clk edge that samples the final s_clk high.
- s_clr high during SHIFT:
  - Counter > 0: err pulses, the state goes to CLEAR, and data is unchanged.
  - Counter == 0: go to CLEAR with no err.
- Timeout:
  - In SHIFT with counter > 0, the timeout counter increments each cycle without a rise.
  - On reaching TIMEOUT_CYCLES-1: err pulses and the state goes to IDLE; data is unchanged.
  - The timeout counter is held at 0 in all other states.
- Simultaneous events in SHIFT: s_clr high takes priority over rise, and rise takes priority over timeout.
- valid and err are never high in the same cycle.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.
- Width rules:
  - Bit counter width = $clog2(DATA_BITS+1).
  - Timeout counter width = $clog2(TIMEOUT_CYCLES+1).
  - DATA_BITS = 1 is legal: the first rise in SHIFT completes the frame.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2.
  - Clog2 width helper constants.
- Sub-module sync_edge: SYNC_STAGES synchronizer plus one-cycle delay flop. Outputs the synchronized level and a rise pulse.
  - One instance for s_clk (level and rise).
  - Level outputs only for s_clr and s_dat.
- Top level contains the FSM, the shift register, both counters, and the output registers.

Test Plan:
- Reset and idle:
  - Hold rst low 5 cycles, then release and drive 10 s_clk pulses with no s_clr.
  - Required: data=0, valid, err and busy all stay 0 throughout.
- Loopback, MSB first:
  - parallel2serial (100/20 MHz, DATA_BITS=32, READ_DIRECTION=1) sends 32'hA5C3_0F81.
  - Required: data=32'hA5C3_0F81, exactly one valid pulse, busy low afterwards.
- LSB first:
  - READ_DIRECTION=0 on both ends; send 32'h0000_0001, then 32'h8000_0000.
  - Required: both words received exactly, two valid pulses.
- Mid-frame clear:
  - After 13 bits, assert s_clr, then send a full frame of 32'h1234_5678.
  - Required: one err pulse, data unchanged after the err, then data=32'h1234_5678 with one valid pulse.
- Timeout:
  - After 5 bits, stop s_clk for 80 cycles (TIMEOUT_CYCLES=64).
  - Required: err pulses 64 cycles after the last rise, state returns to IDLE, no valid pulse.
- Async reset mid-frame:
  - Pull rst low after 20 bits, release it, then send 32'hFFFF_0000.
  - Required: outputs 0 during reset, then data=32'hFFFF_0000 with one valid pulse.
